// File: rtl/ext_bus_if.sv
// CPU-side asynchronous memory bus: address, split data paths, pad enable and active-low strobes.
interface ext_bus_if;
  logic [15:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        oe;
  logic        rdn;
  logic        wr0n;
  logic        wr1n;

  modport master (output addr, din, rdn, wr0n, wr1n, input dout, oe);
  modport slave  (input addr, din, rdn, wr0n, wr1n, output dout, oe);
endinterface

// File: rtl/ext_bus_target.sv
// Bench-side responder on the CPU external bus: scratch, status, CPU->tester mailbox FIFO and
// tester->CPU command register with level interrupt. Strobes are asynchronous and synchronized here.
module ext_bus_target #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int unsigned FIFO_AW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  ext_bus_if.slave        bus,
  output logic [15:0]     tb_data,
  output logic            tb_valid,
  input  logic            tb_ready,
  input  logic [15:0]     tb_cmd,
  input  logic            tb_cmd_wr,
  output logic            irq
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    RD_END    = 3'd2,
    WRITE     = 3'd3,
    WR_COMMIT = 3'd4,
    ERR       = 3'd5
  } state_t;

  state_t state, next_state;
  logic [1:0] rdn_sync, wr0n_sync, wr1n_sync;
  logic s_rdn, s_wr0n, s_wr1n, wr_act;
  logic cap_rd, cap_wr, wr_first, rd_end, wr_commit, err_flag;
  logic [15:0] rd_addr, wr_addr, wr_data, rd_word, status_word, push_word, head_next, scratch, cmd;
  logic [1:0] wr_lanes;
  logic oe_r, cmd_valid, overflow, proto_err, in_hit, rd_hit, wr_hit;
  logic [15:0] dout_r;
  logic [15:0] mem [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
  logic [FIFO_AW:0] count, count_next;
  logic full, empty, push, pop, push_ok, ovf_set, status_clr, cmd_clr;

  assign s_rdn  = rdn_sync[1];
  assign s_wr0n = wr0n_sync[1];
  assign s_wr1n = wr1n_sync[1];
  assign wr_act = ~s_wr0n | ~s_wr1n;

  assign in_hit = (bus.addr[15:2] == BASE_ADDR[15:2]);
  assign rd_hit = (rd_addr[15:2] == BASE_ADDR[15:2]);
  assign wr_hit = (wr_addr[15:2] == BASE_ADDR[15:2]);

  assign bus.oe   = oe_r;
  assign bus.dout = dout_r;
  assign irq      = cmd_valid;

  // Two-stage synchronizers; strobes idle high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdn_sync  <= 2'b11;
      wr0n_sync <= 2'b11;
      wr1n_sync <= 2'b11;
    end else begin
      rdn_sync  <= {rdn_sync[0], bus.rdn};
      wr0n_sync <= {wr0n_sync[0], bus.wr0n};
      wr1n_sync <= {wr1n_sync[0], bus.wr1n};
    end
  end

  // Bus cycle state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    next_state = state;
    cap_rd     = 1'b0;
    cap_wr     = 1'b0;
    wr_first   = 1'b0;
    rd_end     = 1'b0;
    wr_commit  = 1'b0;
    err_flag   = 1'b0;
    case (state)
      IDLE: begin
        if (~s_rdn & wr_act) begin
          next_state = ERR;
        end else if (~s_rdn) begin
          next_state = READ;
          cap_rd     = 1'b1;
        end else if (wr_act) begin
          next_state = WRITE;
          cap_wr     = 1'b1;
          wr_first   = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      READ: begin
        if (s_rdn) next_state = RD_END;
        else       cap_rd = 1'b1;
      end
      RD_END: begin
        rd_end     = 1'b1;
        next_state = IDLE;
      end
      WRITE: begin
        if (~s_rdn)       next_state = ERR;
        else if (~wr_act) next_state = WR_COMMIT;
        else              cap_wr = 1'b1;
      end
      WR_COMMIT: begin
        wr_commit  = 1'b1;
        next_state = IDLE;
      end
      ERR: begin
        err_flag = 1'b1;
        if (s_rdn & ~wr_act) next_state = IDLE;
        else                 next_state = ERR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Read mux over the register window, indexed by the live address.
  always_comb begin
    status_word = 16'h0000;
    status_word[15] = cmd_valid;
    status_word[14] = full;
    status_word[13] = empty;
    status_word[12] = overflow;
    status_word[11] = proto_err;
    status_word[FIFO_AW:0] = count;
    case (bus.addr[1:0])
      2'd0:    rd_word = scratch;
      2'd1:    rd_word = status_word;
      2'd2:    rd_word = tb_data;
      2'd3:    rd_word = cmd;
      default: rd_word = 16'h0000;
    endcase
  end

  // Read path: pad enable and data are re-evaluated every READ cycle; leaving READ drops OE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_r    <= 1'b0;
      dout_r  <= 16'h0000;
      rd_addr <= 16'h0000;
    end else if (cap_rd) begin
      oe_r    <= in_hit;
      dout_r  <= rd_word;
      rd_addr <= bus.addr;
    end else begin
      oe_r    <= 1'b0;
      dout_r  <= 16'h0000;
    end
  end

  // Write capture; lane flags accumulate across the whole strobe window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr  <= 16'h0000;
      wr_data  <= 16'h0000;
      wr_lanes <= 2'b00;
    end else if (cap_wr) begin
      wr_addr  <= bus.addr;
      wr_data  <= bus.din;
      wr_lanes <= (wr_first ? 2'b00 : wr_lanes) | {~s_wr1n, ~s_wr0n};
    end
  end

  assign push       = wr_commit & wr_hit & (wr_addr[1:0] == 2'd2);
  assign status_clr = rd_end & rd_hit & (rd_addr[1:0] == 2'd1);
  assign cmd_clr    = rd_end & rd_hit & (rd_addr[1:0] == 2'd3);
  assign push_word  = {wr_lanes[1] ? wr_data[15:8] : 8'h00, wr_lanes[0] ? wr_data[7:0] : 8'h00};
  assign full       = (count == CNT_FULL);
  assign empty      = (count == {(FIFO_AW+1){1'b0}});
  assign pop        = tb_valid & tb_ready;
  assign push_ok    = push & (~full | pop);
  assign ovf_set    = push & full & ~pop;
  assign rd_next    = pop ? rd_ptr + PTR_ONE : rd_ptr;
  assign wr_next    = push_ok ? wr_ptr + PTR_ONE : wr_ptr;

  // Next occupancy and next head word, bypassing a word written into the new head slot.
  always_comb begin
    if (push_ok & ~pop)      count_next = count + CNT_ONE;
    else if (pop & ~push_ok) count_next = count - CNT_ONE;
    else                     count_next = count;
    if (count_next == {(FIFO_AW+1){1'b0}}) head_next = 16'h0000;
    else if (push_ok && (wr_ptr == rd_next)) head_next = push_word;
    else head_next = mem[rd_next];
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers, occupancy and registered tester-side head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= {FIFO_AW{1'b0}};
      wr_ptr   <= {FIFO_AW{1'b0}};
      count    <= {(FIFO_AW+1){1'b0}};
      tb_valid <= 1'b0;
      tb_data  <= 16'h0000;
    end else begin
      rd_ptr   <= rd_next;
      wr_ptr   <= wr_next;
      count    <= count_next;
      tb_valid <= (count_next != {(FIFO_AW+1){1'b0}});
      tb_data  <= head_next;
    end
  end

  // Scratch, command and sticky flags; event sets take priority over read clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch   <= 16'h0000;
      cmd       <= 16'h0000;
      cmd_valid <= 1'b0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (wr_commit & wr_hit & (wr_addr[1:0] == 2'd0)) begin
        if (wr_lanes[0]) scratch[7:0]  <= wr_data[7:0];
        if (wr_lanes[1]) scratch[15:8] <= wr_data[15:8];
      end
      if (tb_cmd_wr) begin
        cmd       <= tb_cmd;
        cmd_valid <= 1'b1;
      end else if (cmd_clr) begin
        cmd_valid <= 1'b0;
      end
      if (ovf_set)         overflow <= 1'b1;
      else if (status_clr) overflow <= 1'b0;
      if (err_flag)        proto_err <= 1'b1;
      else if (status_clr) proto_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ext_bus_target.sv
// Randomized self-checking bench for ext_bus_target against a register/queue model of the target.
module tb_ext_bus_target;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] tb_data;
  logic tb_valid, tb_ready, tb_cmd_wr, irq;
  logic [15:0] tb_cmd;
  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_scratch, m_cmd;
  bit m_cmd_valid, m_ovf, m_perr;
  logic [15:0] m_fifo[$];

  always #5 clk = ~clk;

  ext_bus_if bus();

  ext_bus_target #(.BASE_ADDR(16'hFF00), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tb_data(tb_data), .tb_valid(tb_valid), .tb_ready(tb_ready),
    .tb_cmd(tb_cmd), .tb_cmd_wr(tb_cmd_wr), .irq(irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_hit(input logic [15:0] a);
    return (a >= 16'hFF00) && (a <= 16'hFF03);
  endfunction

  function automatic logic [15:0] m_read(input logic [1:0] r);
    logic [15:0] s;
    int n;
    n = m_fifo.size();
    s = 16'(n);
    if (m_cmd_valid) s = s + 16'h8000;
    if (n == 8)      s = s + 16'h4000;
    if (n == 0)      s = s + 16'h2000;
    if (m_ovf)       s = s + 16'h1000;
    if (m_perr)      s = s + 16'h0800;
    case (r)
      2'd0:    return m_scratch;
      2'd1:    return s;
      2'd2:    return (n == 0) ? 16'h0000 : m_fifo[0];
      default: return m_cmd;
    endcase
  endfunction

  task automatic model_reset();
    m_scratch = 16'h0000; m_cmd = 16'h0000;
    m_cmd_valid = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
    m_fifo.delete();
  endtask

  task automatic check_tester();
    check_eq("tb_valid", tb_valid, m_fifo.size() != 0);
    check_eq("tb_data", tb_data, (m_fifo.size() != 0) ? m_fifo[0] : 16'h0000);
    check_eq("irq", irq, m_cmd_valid);
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic cpu_read(input logic [15:0] a, input bit cmd_in_end, input logic [15:0] new_cmd,
                          output logic [15:0] got);
    bit hit;
    logic [15:0] exp;
    hit = m_hit(a);
    exp = m_read(a[1:0]);
    bus.addr = a; bus.rdn = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_eq("rd_oe_early", bus.oe, 1'b0);
    @(posedge clk);
    #1 check_eq("rd_oe_latency", bus.oe, hit);
    repeat (2) @(posedge clk);
    #1 got = bus.dout;
    if (hit) check_eq("rd_data", got, exp);
    else     check_eq("rd_oe_miss", bus.oe, 1'b0);
    bus.rdn = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_eq("rd_end_oe", bus.oe, 1'b0);
    if (cmd_in_end) begin
      tb_cmd = new_cmd; tb_cmd_wr = 1'b1;
    end
    @(posedge clk);
    #1 tb_cmd_wr = 1'b0;
    if (hit && a[1:0] == 2'd1) begin m_ovf = 1'b0; m_perr = 1'b0; end
    if (hit && a[1:0] == 2'd3) m_cmd_valid = 1'b0;
    if (cmd_in_end) begin m_cmd = new_cmd; m_cmd_valid = 1'b1; end
    @(posedge clk);
    #1 check_tester();
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] lanes);
    bus.addr = a; bus.din = d; bus.wr0n = ~lanes[0]; bus.wr1n = ~lanes[1];
    repeat (5) @(posedge clk);
    #1 bus.wr0n = 1'b1; bus.wr1n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    if (m_hit(a) && a[1:0] == 2'd0) begin
      if (lanes[0]) m_scratch[7:0]  = d[7:0];
      if (lanes[1]) m_scratch[15:8] = d[15:8];
    end
    if (m_hit(a) && a[1:0] == 2'd2) begin
      if (m_fifo.size() == 8) m_ovf = 1'b1;
      else m_fifo.push_back({lanes[1] ? d[15:8] : 8'h00, lanes[0] ? d[7:0] : 8'h00});
    end
    check_eq("wr_oe_idle", bus.oe, 1'b0);
    check_tester();
  endtask

  task automatic tester_pop();
    check_eq("pop_valid", tb_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) begin
      check_eq("pop_data", tb_data, m_fifo[0]);
      tb_ready = 1'b1;
      @(posedge clk);
      #1 tb_ready = 1'b0;
      void'(m_fifo.pop_front());
    end
  endtask

  task automatic tester_cmd(input logic [15:0] v);
    tb_cmd = v; tb_cmd_wr = 1'b1;
    @(posedge clk);
    #1 tb_cmd_wr = 1'b0;
    m_cmd = v; m_cmd_valid = 1'b1;
    check_eq("cmd_irq", irq, m_cmd_valid);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d, a;
    int op;
    rst = 1'b1; tb_ready = 1'b0; tb_cmd = 16'h0000; tb_cmd_wr = 1'b0;
    bus.addr = 16'h0000; bus.din = 16'h0000; bus.rdn = 1'b1; bus.wr0n = 1'b1; bus.wr1n = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("reset_oe", bus.oe, 1'b0);
    check_eq("reset_dout", bus.dout, 16'h0000);
    check_tester();

    cpu_read(16'hFF01, 1'b0, 16'h0000, d);
    check_eq("status_after_reset", d, 16'h2000);

    cpu_write(16'hFF00, 16'hAB55, 2'b10);
    cpu_write(16'hFF00, 16'h12CD, 2'b01);
    cpu_read(16'hFF00, 1'b0, 16'h0000, d);
    check_eq("scratch_lanes", d, 16'hABCD);

    for (int i = 1; i <= 9; i++) cpu_write(16'hFF02, 16'(i), 2'b11);
    cpu_read(16'hFF01, 1'b0, 16'h0000, d);
    check_eq("status_full_ovf", d, 16'h5008);
    cpu_read(16'hFF01, 1'b0, 16'h0000, d);
    check_eq("status_ovf_cleared", d, 16'h4008);
    cpu_read(16'hFF02, 1'b0, 16'h0000, d);
    check_eq("data_peek", d, 16'h0001);
    for (int i = 1; i <= 8; i++) begin
      check_eq("pop_order", tb_data, 16'(i));
      tester_pop();
    end
    check_eq("drained_valid", tb_valid, 1'b0);

    tester_cmd(16'hBEEF);
    cpu_read(16'hFF03, 1'b0, 16'h0000, d);
    check_eq("cmd_read", d, 16'hBEEF);
    check_eq("irq_cleared", irq, 1'b0);
    tester_cmd(16'h1234);
    cpu_read(16'hFF03, 1'b1, 16'h5678, d);
    check_eq("irq_load_wins", irq, 1'b1);
    cpu_read(16'hFF03, 1'b0, 16'h0000, d);
    check_eq("cmd_reload", d, 16'h5678);

    bus.addr = 16'hFF00; bus.din = 16'hDEAD; bus.rdn = 1'b0; bus.wr0n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check_eq("err_oe", bus.oe, 1'b0);
    end
    bus.rdn = 1'b1; bus.wr0n = 1'b1;
    repeat (6) @(posedge clk);
    #1 m_perr = 1'b1;
    cpu_read(16'hFF01, 1'b0, 16'h0000, d);
    check_eq("perr_bit", d[11], 1'b1);
    cpu_read(16'hFF00, 1'b0, 16'h0000, d);
    check_eq("err_no_write", d, 16'hABCD);

    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 4);
      a = ($urandom_range(0, 5) == 0) ? (16'h1200 | 16'($urandom_range(0, 255)))
                                      : (16'hFF00 | 16'($urandom_range(0, 3)));
      case (op)
        0, 1: cpu_write(a, 16'($urandom), 2'($urandom_range(1, 3)));
        2: cpu_read(a, $urandom_range(0, 3) == 0, 16'($urandom), d);
        3: tester_pop();
        default: tester_cmd(16'($urandom));
      endcase
    end

    cpu_write(16'hFF00, 16'h5A5A, 2'b11);
    cpu_write(16'hFF02, 16'hC0DE, 2'b11);
    bus.addr = 16'hFF01; bus.rdn = 1'b0;
    repeat (4) @(posedge clk);
    #3 check_eq("oe_before_rst", bus.oe, 1'b1);
    rst = 1'b1;
    #1 check_eq("oe_async_rst", bus.oe, 1'b0);
    bus.rdn = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check_tester();
    cpu_read(16'hFF00, 1'b0, 16'h0000, d);
    check_eq("scratch_after_rst", d, 16'h0000);
    cpu_read(16'hFF01, 1'b0, 16'h0000, d);
    check_eq("status_after_rst", d, 16'h2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ext_bus_target.md
Name: ext_bus_target

Overview:
- Synthesizable target (responder) on the external asynchronous memory bus driven by the CPU (RDN, WR0N, WR1N, 16-bit address, bidirectional 16-bit data).
- Sits on the board/bench side of the pins; gives test programs a scratch register, a status register, a CPU→tester mailbox FIFO and a tester→CPU command register with interrupt.
- All bus strobes are asynchronous to CLK and are synchronized internally.

Parameters:
- BASE_ADDR, 16'hFF00: word address of the register window. Hit when ADDR[15:2] == BASE_ADDR[15:2].
- FIFO_AW, 3: mailbox FIFO address width. Depth is 2^FIFO_AW = 8.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- BUS_ADDR  in  16  address bus from the CPU pins.
- BUS_DIN  in  16  data bus input path (CPU write data).
- BUS_DOUT  out  16  read data to the data-bus pad.
- BUS_OE  out  1  pad output enable; high = target drives the bus.
- RDN  in  1  read strobe, active low, asynchronous.
- WR0N  in  1  low-byte write strobe, active low, asynchronous.
- WR1N  in  1  high-byte write strobe, active low, asynchronous.
- TB_DATA  out  16  FIFO head word.
- TB_VALID  out  1  FIFO non-empty.
- TB_READY  in  1  tester pop. A pop occurs when TB_VALID & TB_READY.
- TB_CMD  in  16  command word from the tester.
- TB_CMD_WR  in  1  one-cycle pulse; loads TB_CMD.
- IRQ  out  1  level interrupt = CMD_VALID.

Behaviour:
- Reset (async): all outputs 0, FIFO empty, CMD_VALID/OVERFLOW/PROTO_ERR = 0, SCRATCH = 0, FSM = IDLE. BUS_OE drops immediately, including mid-cycle.
- Synchronization: RDN, WR0N and WR1N each pass through a 2-FF synchronizer. WR_ACT = ~sWR0N | ~sWR1N.
- FSM states:
  - IDLE: ~sRDN & WR_ACT → ERR. ~sRDN → READ. WR_ACT → WRITE.
  - READ: captures ADDR every cycle. BUS_OE asserts the cycle after entry if hit. BUS_DOUT registered from the currently captured address. sRDN high → RD_END (BUS_OE = 0 same edge).
  - RD_END (1 cycle): applies read side effects → IDLE.
  - WRITE: every cycle captures ADDR, DIN, and lane flags (lane flags OR-accumulate). Both strobes synced high → WR_COMMIT. If ~sRDN seen → ERR.
  - WR_COMMIT (1 cycle): applies the write using the last captured values → IDLE.
  - ERR: sets PROTO_ERR; no commit, no drive; returns to IDLE when all strobes are synced high.
- Read latency: BUS_OE is high 3 CLK after the RDN falling edge. Write data must be stable ≥3 CLK before strobe release.
- Register map (ADDR[1:0]):
  - 0 SCRATCH: RW with byte lanes; WR0N → [7:0], WR1N → [15:8].
  - 1 STATUS: RO. [15] CMD_VALID, [14] FULL, [13] EMPTY, [12] OVERFLOW, [11] PROTO_ERR, [10:4] 0, [3:0] count (0..8). Read end clears OVERFLOW and PROTO_ERR.
  - 2 DATA: write pushes {lane1 ? DIN[15:8] : 8'h00, lane0 ? DIN[7:0] : 8'h00}. Read returns the head word (0 if empty) with no pop.
  - 3 CMD: RO, returns the CMD word. Read end clears CMD_VALID.
  - Writes to RO registers and all accesses outside the window: no effect, BUS_OE stays 0.
- FIFO:
  - Push when full: word dropped, OVERFLOW set.
  - Push and pop in the same cycle: both apply, count unchanged, including when full (push accepted) and when empty (no pop, since TB_VALID = 0).
  - Count saturates at 8. Pointers wrap modulo 8.
- TB_DATA/TB_VALID update the cycle after a push or pop. TB_VALID is 0 while empty.
- TB_CMD_WR: CMD ← TB_CMD, CMD_VALID ← 1. If coincident with the CMD-read clear, the load wins and CMD_VALID stays 1.
- Event sets win over status-read clears in the same cycle (OVERFLOW, PROTO_ERR).

Test Plan:
- Reset, then read STATUS at FF01 → BUS_OE high 3 CLK after RDN falls; data 16'h2000 (EMPTY); IRQ = 0.
- WR1N-only write 0xAB55 to FF00, then WR0N-only write 0x12CD → SCRATCH reads 0xABCD.
- 9 full-word writes 0x0001..0x0009 to FF02, TB_READY = 0 → STATUS = 0x5008 (FULL | OVERFLOW, count 8). Second STATUS read = 0x4008. Pops yield 0x0001..0x0008 in order, then TB_VALID = 0.
- TB_CMD_WR with 0xBEEF → IRQ = 1 next cycle. CPU read of FF03 returns 0xBEEF; IRQ = 0 after RD_END. Repeat with TB_CMD_WR pulsed exactly in RD_END → IRQ stays 1.
- RDN and WR0N low together → no register change, BUS_OE = 0, next STATUS read has bit 11 set.
- Assert RESET with BUS_OE high mid-read → BUS_OE = 0 without a clock edge; FIFO empty; SCRATCH = 0.
